edge_detect: RTL and testbench

//  - Per-bit rising/falling edge detector for level signals (GPIO, button, handshake lines).
//  - Samples input history on clk; flags 0->1 and 1->0 transitions as pulses.
//  - Optional input synchroniser; optional registered outputs.
//  - Feeds interrupt/event logic inside the MCU peripheral subsystem.

---
 rtl/edge_detect_pkg.sv | 25 ++
 rtl/edge_detect_if.sv | 31 +++
 rtl/edge_sync.sv | 34 +++
 rtl/edge_detect.sv | 90 +++++++++
 tb/tb_edge_detect.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/edge_detect_pkg.sv
// edge_detect_pkg: shared defaults and types for the edge detector.
//   DEF_WIDTH / DEF_SYNC_STAGES / DEF_REG_OUT : default parameter values
//   edge_t   : per-channel {rise, fall} pair
//   classify : edge terms from the current and previous sampled level
package edge_detect_pkg;

  localparam int DEF_WIDTH       = 1;
  localparam int DEF_SYNC_STAGES = 0;
  localparam bit DEF_REG_OUT     = 1'b0;

  typedef struct packed {
    logic rise;
    logic fall;
  } edge_t;

  // The two terms are mutually exclusive by construction, so a channel
  // can never report a rise and a fall at the same time.
  function automatic edge_t classify(input logic cur, input logic prev);
    edge_t e;
    e.rise = cur & ~prev;
    e.fall = ~cur & prev;
    return e;
  endfunction

endpackage

// File: rtl/edge_detect_if.sv
// edge_detect_if: level inputs and edge pulse outputs of the edge detector.
//   sig_now      : monitored level signal(s)      (master -> slave)
//   rising_edge  : 0->1 pulse per channel         (slave -> master)
//   falling_edge : 1->0 pulse per channel         (slave -> master)
//   any_edge     : rising_edge | falling_edge     (slave -> master)
interface edge_detect_if
  import edge_detect_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic [WIDTH-1:0] sig_now;
  logic [WIDTH-1:0] rising_edge;
  logic [WIDTH-1:0] falling_edge;
  logic [WIDTH-1:0] any_edge;

  modport master (
    output sig_now,
    input  rising_edge,
    input  falling_edge,
    input  any_edge
  );

  modport slave (
    input  sig_now,
    output rising_edge,
    output falling_edge,
    output any_edge
  );

endinterface

// File: rtl/edge_sync.sv
// edge_sync: WIDTH-wide, STAGES-deep flop chain used to bring asynchronous
// level inputs into the clk domain.
//   clk   : rising-edge clock
//   clr_i : synchronous active-high clear of every stage
//   d_i   : raw input levels
//   q_o   : levels after STAGES flops
module edge_sync
  import edge_detect_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [STAGES-1:0][WIDTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (clr_i) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/edge_detect.sv
// edge_detect: per-bit rising/falling edge detector for level signals.
//   clk  : rising-edge clock
//   rstn : synchronous reset, active HIGH despite the name
//   bus  : edge_detect_if.slave (sig_now in; rising_edge, falling_edge,
//          any_edge out)
// Params: WIDTH channels, SYNC_STAGES input flops (0 = bypass),
//         REG_OUT (1 = registered outputs, one extra cycle of latency).
module edge_detect
  import edge_detect_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter bit REG_OUT     = DEF_REG_OUT
) (
  input  logic          clk,
  input  logic          rstn,
  edge_detect_if.slave  bus
);

  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] sig_prev_q, sig_prev_d;
  logic [WIDTH-1:0] rise_c, fall_c;
  logic [WIDTH-1:0] rise_out, fall_out;
  edge_t [WIDTH-1:0] edge_c;

  generate
    if (SYNC_STAGES > 0) begin : g_sync
      edge_sync #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
      ) u_sync (
        .clk   (clk),
        .clr_i (rstn),
        .d_i   (bus.sig_now),
        .q_o   (s)
      );
    end else begin : g_nosync
      assign s = bus.sig_now;
    end
  endgenerate

  // History starts at 0 after reset, so an input already high when reset
  // releases is reported as one rising edge.
  assign sig_prev_d = s;

  always_ff @(posedge clk) begin
    if (rstn) sig_prev_q <= '0;
    else      sig_prev_q <= sig_prev_d;
  end

  always_comb begin
    edge_c = '0;
    rise_c = '0;
    fall_c = '0;
    for (int i = 0; i < WIDTH; i++) begin
      edge_c[i] = classify(s[i], sig_prev_q[i]);
      rise_c[i] = edge_c[i].rise;
      fall_c[i] = edge_c[i].fall;
    end
  end

  generate
    if (REG_OUT) begin : g_regout
      logic [WIDTH-1:0] rise_q, fall_q;

      always_ff @(posedge clk) begin
        if (rstn) begin
          rise_q <= '0;
          fall_q <= '0;
        end else begin
          rise_q <= rise_c;
          fall_q <= fall_c;
        end
      end

      assign rise_out = rise_q;
      assign fall_out = fall_q;
    end else begin : g_combout
      assign rise_out = rise_c;
      assign fall_out = fall_c;
    end
  endgenerate

  // Gate with reset so a pending pulse disappears the moment reset is
  // asserted, not only after the next edge; this also holds in comb mode.
  assign bus.rising_edge  = rise_out & {WIDTH{~rstn}};
  assign bus.falling_edge = fall_out & {WIDTH{~rstn}};
  assign bus.any_edge     = (rise_out | fall_out) & {WIDTH{~rstn}};

endmodule

// File: tb/tb_edge_detect.sv
// tb_edge_detect: two detector instances, a default one (WIDTH=1, no sync,
// comb outputs) and a WIDTH=4 / SYNC_STAGES=2 / REG_OUT=1 one. Inputs are
// driven 1 time unit after a posedge, outputs sampled on the negedge.
module tb_edge_detect;
  import edge_detect_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1;

  edge_detect_if #(.WIDTH(1)) bus0 ();
  edge_detect_if #(.WIDTH(4)) bus1 ();

  edge_detect #(.WIDTH(1), .SYNC_STAGES(0), .REG_OUT(1'b0)) u_dut0 (
    .clk  (clk),
    .rstn (rst0),
    .bus  (bus0)
  );

  edge_detect #(.WIDTH(4), .SYNC_STAGES(2), .REG_OUT(1'b1)) u_dut1 (
    .clk  (clk),
    .rstn (rst1),
    .bus  (bus1)
  );

  typedef struct {
    logic       rst;
    logic [3:0] sig;
    logic [3:0] rise;
    logic [3:0] fall;
  } vec_t;

  typedef struct {
    logic [3:0] rise;
    logic [3:0] fall;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // One cycle on the wide instance: drive, push expectation, compare at negedge.
  task automatic step1(input logic rst, input logic [3:0] sig,
                       input logic [3:0] er, input logic [3:0] ef,
                       input string name, input bit glitch);
    exp_t e;
    @(posedge clk);
    #1;
    rst1 = rst;
    if (glitch) begin
      bus1.sig_now = sig ^ 4'hF;
      #1;
    end
    bus1.sig_now = sig;
    sb.push_back('{rise: er, fall: ef});
    @(negedge clk);
    e = sb.pop_front();
    check({name, ".rise"}, bus1.rising_edge, e.rise);
    check({name, ".fall"}, bus1.falling_edge, e.fall);
    check({name, ".any"}, bus1.any_edge, e.rise | e.fall);
    check({name, ".excl"}, bus1.rising_edge & bus1.falling_edge, 4'h0);
  endtask

  vec_t       tbl[20];
  logic [3:0] hist[$];
  logic [3:0] exp_hold[6];
  logic [3:0] exp_post[5];

  initial begin
    rst0 = 1'b1;
    rst1 = 1'b1;
    bus0.sig_now = 1'b0;
    bus1.sig_now = 4'h0;

    // rst, sig, rise, fall  (one row per clock cycle, default instance)
    tbl[0]  = '{1'b1, 4'h0, 4'h0, 4'h0};  // reset
    tbl[1]  = '{1'b1, 4'h0, 4'h0, 4'h0};
    tbl[2]  = '{1'b0, 4'h0, 4'h0, 4'h0};  // release, quiet
    tbl[3]  = '{1'b0, 4'h1, 4'h1, 4'h0};  // rise
    tbl[4]  = '{1'b0, 4'h1, 4'h0, 4'h0};  // pulse ends at posedge
    tbl[5]  = '{1'b0, 4'h1, 4'h0, 4'h0};
    tbl[6]  = '{1'b0, 4'h0, 4'h0, 4'h1};  // fall
    tbl[7]  = '{1'b0, 4'h0, 4'h0, 4'h0};
    tbl[8]  = '{1'b0, 4'h1, 4'h1, 4'h0};  // rise
    tbl[9]  = '{1'b1, 4'h1, 4'h0, 4'h0};  // reset kills it
    tbl[10] = '{1'b0, 4'h1, 4'h1, 4'h0};  // held high: rise after reset
    tbl[11] = '{1'b0, 4'h1, 4'h0, 4'h0};  // steady high
    tbl[12] = '{1'b0, 4'h1, 4'h0, 4'h0};
    tbl[13] = '{1'b0, 4'h1, 4'h0, 4'h0};
    tbl[14] = '{1'b0, 4'h1, 4'h0, 4'h0};
    tbl[15] = '{1'b0, 4'h1, 4'h0, 4'h0};
    tbl[16] = '{1'b0, 4'h0, 4'h0, 4'h1};  // single fall
    tbl[17] = '{1'b0, 4'h0, 4'h0, 4'h0};
    tbl[18] = '{1'b1, 4'h1, 4'h0, 4'h0};  // rise masked by reset
    tbl[19] = '{1'b0, 4'h0, 4'h0, 4'h0};  // nothing replayed

    for (int r = 0; r < 20; r++) begin
      exp_t e;
      string nm;
      @(posedge clk);
      #1;
      rst0 = tbl[r].rst;
      bus0.sig_now = tbl[r].sig[0];
      sb.push_back('{rise: tbl[r].rise, fall: tbl[r].fall});
      @(negedge clk);
      e = sb.pop_front();
      nm = $sformatf("d0.row%0d", r);
      check({nm, ".rise"}, {3'b0, bus0.rising_edge}, e.rise);
      check({nm, ".fall"}, {3'b0, bus0.falling_edge}, e.fall);
      check({nm, ".any"}, {3'b0, bus0.any_edge}, e.rise | e.fall);
      if (r == 1) check("d0.reset.sig_prev", {3'b0, u_dut0.sig_prev_q}, 4'h0);
    end

    // Wide instance: 0000 -> 0101 appears three posedges later for one cycle.
    exp_hold[0] = 4'h0; exp_hold[1] = 4'h0; exp_hold[2] = 4'h0;
    exp_hold[3] = 4'h5; exp_hold[4] = 4'h0; exp_hold[5] = 4'h0;
    for (int i = 0; i < 4; i++) hist.push_back(4'h0);
    for (int k = 0; k < 6; k++) begin
      hist.push_back(4'h5);
      step1(1'b0, 4'h5, exp_hold[k], 4'h0, $sformatf("d1.hold%0d", k), 1'b0);
    end

    // Random levels, some with a glitch inside the cycle; expectation is the
    // edge of the value sampled three and four cycles back.
    for (int k = 0; k < 40; k++) begin
      logic [3:0] v;
      int n;
      v = 4'($urandom_range(0, 15));
      hist.push_back(v);
      n = hist.size();
      step1(1'b0, v, hist[n-4] & ~hist[n-5], ~hist[n-4] & hist[n-5],
            $sformatf("d1.rnd%0d", k), (k % 5) == 0);
    end

    // Quiet, then all high, then reset exactly when the rise would show.
    for (int k = 0; k < 7; k++) begin
      logic [3:0] v;
      int n;
      v = (k < 4) ? 4'h0 : 4'hF;
      hist.push_back(v);
      n = hist.size();
      step1(1'b0, v, hist[n-4] & ~hist[n-5], ~hist[n-4] & hist[n-5],
            $sformatf("d1.pre%0d", k), 1'b0);
    end
    step1(1'b1, 4'hF, 4'h0, 4'h0, "d1.rst_mid", 1'b0);

    // Held high after reset: exactly one fresh rise, pipeline latency again.
    exp_post[0] = 4'h0; exp_post[1] = 4'h0; exp_post[2] = 4'h0;
    exp_post[3] = 4'hF; exp_post[4] = 4'h0;
    for (int k = 0; k < 5; k++) begin
      step1(1'b0, 4'hF, exp_post[k], 4'h0, $sformatf("d1.post%0d", k), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
